sysid_check_ctrl: RTL and testbench



---
 rtl/sysid_check_pkg.sv | 29 ++
 rtl/sysid_read_engine.sv | 56 +++++
 rtl/sysid_check_ctrl.sv | 166 ++++++++++++++++
 tb/tb_sysid_check_ctrl.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the system-ID boot checker.
// The Avalon slave exposes the ID at word 0 and the build timestamp at word 1.
package sysid_check_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StIdRd,
      StIdWait,
      StTsRd,
      StTsWait,
      StEval
   } state_e;

   localparam logic [31:0] DEFAULT_EXP_ID        = 32'h0400_0000;
   localparam logic [31:0] DEFAULT_EXP_TIMESTAMP = 32'd1417718146;

   localparam logic ADDR_ID = 1'b0;
   localparam logic ADDR_TS = 1'b1;

   localparam int unsigned TMR_W = 8;

   function automatic logic words_match(input logic [31:0] id_word,
                                        input logic [31:0] ts_word,
                                        input logic [31:0] exp_id,
                                        input logic [31:0] exp_ts);
      return (id_word == exp_id) && (ts_word == exp_ts);
   endfunction

endpackage

// File: rtl/sysid_read_engine.sv
// Single Avalon-MM read: request handshake, fixed read latency and per-read timeout.
// The controller supplies the phase (request or latency wait); this block reports the events.
module sysid_read_engine
   import sysid_check_pkg::*;
#(
   parameter int unsigned READ_LATENCY   = 0,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clock,
   input  logic reset_n,
   input  logic rd_phase,
   input  logic wait_phase,
   input  logic waitrequest,
   output logic read,
   output logic accept,
   output logic capture,
   output logic expire
);

   localparam logic [TMR_W-1:0] TmrLast = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0]       LatLast = 2'(READ_LATENCY - 1);

   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [1:0]       lat_q, lat_d;
   logic             active;

   always_comb begin
      active = rd_phase | wait_phase;
      read   = rd_phase;
      accept = rd_phase & ~waitrequest;
      if (READ_LATENCY == 0) begin
         capture = accept;
      end else begin
         capture = wait_phase && (lat_q == LatLast);
      end
      // A capture on the final counted cycle still wins over the timeout.
      expire = active && !capture && (tmr_q == TmrLast);

      tmr_d = tmr_q + TMR_W'(1);
      if (!active || capture || expire) begin
         tmr_d = '0;
      end
      lat_d = wait_phase ? (lat_q + 2'd1) : 2'd0;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tmr_q <= '0;
         lat_q <= '0;
      end else begin
         tmr_q <= tmr_d;
         lat_q <= lat_d;
      end
   end

endmodule

// File: rtl/sysid_check_ctrl.sv
// Reads the system-ID and timestamp words, compares them with the expected build values,
// retries on mismatch and publishes sticky pass/mismatch/timeout status.
module sysid_check_ctrl
   import sysid_check_pkg::*;
#(
   parameter logic [31:0] EXP_ID         = DEFAULT_EXP_ID,
   parameter logic [31:0] EXP_TIMESTAMP  = DEFAULT_EXP_TIMESTAMP,
   parameter int unsigned READ_LATENCY   = 0,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned MAX_RETRIES    = 3,
   parameter int unsigned AUTO_START     = 1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        mismatch,
   output logic        timeout,
   output logic [31:0] id_value,
   output logic [31:0] ts_value,
   output logic [1:0]  retry_count
);

   localparam logic [1:0] MaxRetry = 2'(MAX_RETRIES);

   state_e      state_q, state_d;
   logic        pass_q, pass_d;
   logic        mismatch_q, mismatch_d;
   logic        timeout_q, timeout_d;
   logic        done_q, done_d;
   logic [1:0]  retry_q, retry_d;
   logic [31:0] id_q, id_d;
   logic [31:0] ts_q, ts_d;
   logic        auto_q;

   logic rd_phase, wait_phase, is_ts;
   logic accept, capture, expire;

   sysid_read_engine #(
      .READ_LATENCY  (READ_LATENCY),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_engine (
      .clock      (clock),
      .reset_n    (reset_n),
      .rd_phase   (rd_phase),
      .wait_phase (wait_phase),
      .waitrequest(avm_waitrequest),
      .read       (avm_read),
      .accept     (accept),
      .capture    (capture),
      .expire     (expire)
   );

   always_comb begin
      rd_phase    = (state_q == StIdRd) || (state_q == StTsRd);
      wait_phase  = (state_q == StIdWait) || (state_q == StTsWait);
      is_ts       = (state_q == StTsRd) || (state_q == StTsWait);
      avm_address = is_ts ? ADDR_TS : ADDR_ID;
   end

   always_comb begin
      state_d    = state_q;
      pass_d     = pass_q;
      mismatch_d = mismatch_q;
      timeout_d  = timeout_q;
      retry_d    = retry_q;
      id_d       = id_q;
      ts_d       = ts_q;
      done_d     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start || auto_q) begin
               pass_d     = 1'b0;
               mismatch_d = 1'b0;
               timeout_d  = 1'b0;
               retry_d    = '0;
               state_d    = StIdRd;
            end
         end
         StIdRd, StIdWait: begin
            if (capture) begin
               id_d    = avm_readdata;
               state_d = StTsRd;
            end else if (expire) begin
               timeout_d = 1'b1;
               done_d    = 1'b1;
               state_d   = StIdle;
            end else if (accept) begin
               state_d = StIdWait;
            end
         end
         StTsRd, StTsWait: begin
            if (capture) begin
               // The verdict is registered on entry to StEval so done and the flag appear together.
               ts_d    = avm_readdata;
               state_d = StEval;
               if (words_match(id_q, avm_readdata, EXP_ID, EXP_TIMESTAMP)) begin
                  pass_d = 1'b1;
                  done_d = 1'b1;
               end else if (retry_q >= MaxRetry) begin
                  mismatch_d = 1'b1;
                  done_d     = 1'b1;
               end
            end else if (expire) begin
               timeout_d = 1'b1;
               done_d    = 1'b1;
               state_d   = StIdle;
            end else if (accept) begin
               state_d = StTsWait;
            end
         end
         StEval: begin
            if (pass_q || mismatch_q) begin
               state_d = StIdle;
            end else begin
               retry_d = retry_q + 2'd1;
               state_d = StIdRd;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         pass_q     <= 1'b0;
         mismatch_q <= 1'b0;
         timeout_q  <= 1'b0;
         done_q     <= 1'b0;
         retry_q    <= '0;
         id_q       <= '0;
         ts_q       <= '0;
         auto_q     <= (AUTO_START != 0);
      end else begin
         state_q    <= state_d;
         pass_q     <= pass_d;
         mismatch_q <= mismatch_d;
         timeout_q  <= timeout_d;
         done_q     <= done_d;
         retry_q    <= retry_d;
         id_q       <= id_d;
         ts_q       <= ts_d;
         auto_q     <= 1'b0;
      end
   end

   always_comb begin
      busy        = (state_q != StIdle);
      done        = done_q;
      pass        = pass_q;
      mismatch    = mismatch_q;
      timeout     = timeout_q;
      retry_count = retry_q;
      id_value    = id_q;
      ts_value    = ts_q;
   end

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Bench for sysid_check_ctrl: two instances (read latency 0 and 2) against a scripted slave
// whose per-attempt data is chosen at random; outcomes come from an attempt-level model.
module tb_sysid_check_ctrl;

   localparam logic [31:0] EXP_ID = 32'h0400_0000;
   localparam logic [31:0] EXP_TS = 32'd1417718146;
   localparam int MAXR = 3;

   logic clock = 1'b0;
   logic reset_n = 1'b0;

   logic        start [2];
   logic        avm_address [2];
   logic        avm_read [2];
   logic        waitreq [2];
   logic [31:0] readdata [2];
   logic        busy [2];
   logic        done [2];
   logic        pass [2];
   logic        mismatch [2];
   logic        timeout [2];
   logic [31:0] id_value [2];
   logic [31:0] ts_value [2];
   logic [1:0]  retry_count [2];

   // Slave configuration, written only by the stimulus process.
   int          n_bad [2];
   logic [1:0]  bad_sel [2];
   logic [31:0] mask_id [2];
   logic [31:0] mask_ts [2];
   int          base_id [2];
   int          base_ts [2];
   logic        wr_base [2];
   logic        stall_ts [2];

   // Slave observation, written only by the clocked monitor.
   int          id_acc [2];
   int          ts_acc [2];
   int          done_cnt [2];
   int          ts_rd_cycles [2];
   logic [31:0] hold1;
   logic [31:0] word_now [2];

   logic [31:0] last_id [2];
   logic [31:0] last_ts [2];
   int n_checks = 0;
   int n_fail = 0;

   always #5 clock = ~clock;

   sysid_check_ctrl #(.READ_LATENCY(0)) u_dut0 (
      .clock(clock), .reset_n(reset_n), .start(start[0]),
      .avm_address(avm_address[0]), .avm_read(avm_read[0]),
      .avm_waitrequest(waitreq[0]), .avm_readdata(readdata[0]),
      .busy(busy[0]), .done(done[0]), .pass(pass[0]), .mismatch(mismatch[0]),
      .timeout(timeout[0]), .id_value(id_value[0]), .ts_value(ts_value[0]),
      .retry_count(retry_count[0])
   );

   sysid_check_ctrl #(.READ_LATENCY(2)) u_dut2 (
      .clock(clock), .reset_n(reset_n), .start(start[1]),
      .avm_address(avm_address[1]), .avm_read(avm_read[1]),
      .avm_waitrequest(waitreq[1]), .avm_readdata(readdata[1]),
      .busy(busy[1]), .done(done[1]), .pass(pass[1]), .mismatch(mismatch[1]),
      .timeout(timeout[1]), .id_value(id_value[1]), .ts_value(ts_value[1]),
      .retry_count(retry_count[1])
   );

   always_comb begin
      for (int k = 0; k < 2; k++) begin
         int   attempt;
         logic corrupt;
         attempt = avm_address[k] ? (ts_acc[k] - base_ts[k]) : (id_acc[k] - base_id[k]);
         corrupt = (attempt < n_bad[k]) && (avm_address[k] ? bad_sel[k][1] : bad_sel[k][0]);
         if (avm_address[k]) word_now[k] = EXP_TS ^ (corrupt ? mask_ts[k] : 32'h0);
         else                word_now[k] = EXP_ID ^ (corrupt ? mask_id[k] : 32'h0);
         waitreq[k] = wr_base[k] | (stall_ts[k] & avm_address[k]);
      end
      readdata[0] = word_now[0];
      readdata[1] = hold1;
   end

   always @(posedge clock) begin
      for (int k = 0; k < 2; k++) begin
         if (avm_read[k] && !waitreq[k]) begin
            if (avm_address[k]) ts_acc[k] <= ts_acc[k] + 1;
            else                id_acc[k] <= id_acc[k] + 1;
         end
         if (avm_read[k] && avm_address[k]) ts_rd_cycles[k] <= ts_rd_cycles[k] + 1;
         if (done[k]) done_cnt[k] <= done_cnt[k] + 1;
      end
      if (avm_read[1] && !waitreq[1]) hold1 <= word_now[1];
   end

   task automatic test_reset;
      logic [75:0] outs;
      repeat (3) @(negedge clock);
      for (int k = 0; k < 2; k++) begin
         outs = {avm_read[k], avm_address[k], busy[k], done[k], pass[k], mismatch[k],
                 timeout[k], retry_count[k], id_value[k], ts_value[k]};
         n_checks++;
         if (outs !== 76'h0) begin
            n_fail++; $display("FAIL reset_outputs[%0d]: got %h want 0", k, outs);
         end
      end
   endtask

   task automatic test_auto_start;
      int n;
      reset_n = 1'b1;
      @(negedge clock);
      n_checks++;
      if ({avm_read[0], avm_address[0]} !== 2'b10) begin
         n_fail++; $display("FAIL auto_id_read: got %b want 10", {avm_read[0], avm_address[0]});
      end
      @(negedge clock);
      n_checks++;
      if ({avm_read[0], avm_address[0]} !== 2'b11) begin
         n_fail++; $display("FAIL auto_ts_read: got %b want 11", {avm_read[0], avm_address[0]});
      end
      n_checks++;
      if (id_value[0] !== EXP_ID) begin
         n_fail++; $display("FAIL auto_id_value: got %h want %h", id_value[0], EXP_ID);
      end
      @(negedge clock);
      n_checks++;
      if ({done[0], pass[0], busy[0], retry_count[0]} !== 5'b11100) begin
         n_fail++; $display("FAIL auto_done_pass: got %b want 11100",
                            {done[0], pass[0], busy[0], retry_count[0]});
      end
      n_checks++;
      if (ts_value[0] !== EXP_TS) begin
         n_fail++; $display("FAIL auto_ts_value: got %h want %h", ts_value[0], EXP_TS);
      end
      @(negedge clock);
      n_checks++;
      if ({done[0], busy[0], pass[0]} !== 3'b001) begin
         n_fail++; $display("FAIL auto_idle: got %b want 001", {done[0], busy[0], pass[0]});
      end
      n = 0;
      while (busy[1] !== 1'b0 && n < 40) begin @(negedge clock); n++; end
      n_checks++;
      if ({busy[1], pass[1], id_value[1]} !== {2'b01, EXP_ID}) begin
         n_fail++; $display("FAIL auto_lat2: got busy/pass %b%b id %h want 01 %h",
                            busy[1], pass[1], id_value[1], EXP_ID);
      end
      for (int k = 0; k < 2; k++) begin last_id[k] = EXP_ID; last_ts[k] = EXP_TS; end
   endtask

   task automatic test_check_once(input int k, input int nb, input logic [1:0] sel,
                                  input logic [31:0] mid, input logic [31:0] mts,
                                  input string tag);
      logic [31:0] eid, ets;
      bit epass, got;
      int er, elat, en, n, d0;
      epass = 1'b0;
      er = 0;
      eid = EXP_ID;
      ets = EXP_TS;
      for (int a = 0; a <= MAXR; a++) begin
         eid = EXP_ID ^ ((a < nb && sel[0]) ? mid : 32'h0);
         ets = EXP_TS ^ ((a < nb && sel[1]) ? mts : 32'h0);
         er = a;
         if (eid == EXP_ID && ets == EXP_TS) begin epass = 1'b1; break; end
      end
      elat = (k == 0) ? 0 : 2;
      en = 3 + 2 * elat + (2 * elat + 3) * er;

      n_bad[k] = nb; bad_sel[k] = sel; mask_id[k] = mid; mask_ts[k] = mts;
      base_id[k] = id_acc[k]; base_ts[k] = ts_acc[k];
      d0 = done_cnt[k];
      @(negedge clock);
      start[k] = 1'b1;
      n = 0;
      got = 1'b0;
      while (!got && n < 200) begin
         @(negedge clock);
         start[k] = 1'b0;
         n++;
         got = (done[k] === 1'b1);
      end
      n_checks++;
      if (!got || n != en) begin
         n_fail++; $display("FAIL %s done_cycle[%0d]: got %0d (seen %0b) want %0d",
                            tag, k, n, got, en);
      end
      n_checks++;
      if ({pass[k], mismatch[k], timeout[k]} !== {epass, !epass, 1'b0}) begin
         n_fail++; $display("FAIL %s flags[%0d]: got %b want %b", tag, k,
                            {pass[k], mismatch[k], timeout[k]}, {epass, !epass, 1'b0});
      end
      n_checks++;
      if (retry_count[k] !== 2'(er)) begin
         n_fail++; $display("FAIL %s retry[%0d]: got %0d want %0d", tag, k, retry_count[k], er);
      end
      n_checks++;
      if (id_value[k] !== eid || ts_value[k] !== ets) begin
         n_fail++; $display("FAIL %s words[%0d]: got %h/%h want %h/%h", tag, k,
                            id_value[k], ts_value[k], eid, ets);
      end
      repeat (2) @(negedge clock);
      n_checks++;
      if (done_cnt[k] - d0 != 1 || busy[k] !== 1'b0) begin
         n_fail++; $display("FAIL %s one_done[%0d]: got %0d pulses busy %b want 1 busy 0",
                            tag, k, done_cnt[k] - d0, busy[k]);
      end
      last_id[k] = eid;
      last_ts[k] = ets;
   endtask

   task automatic test_random;
      for (int i = 0; i < 10; i++) begin
         test_check_once(i % 2, int'($urandom_range(0, 5)), 2'($urandom_range(1, 3)),
                         $urandom | 32'h1, $urandom | 32'h1, "random");
      end
   endtask

   task automatic test_ts_zero;
      test_check_once(0, 1000, 2'b10, 32'h0, EXP_TS, "ts_zero");
      test_check_once(1, 1000, 2'b10, 32'h0, EXP_TS, "ts_zero_lat2");
   endtask

   task automatic test_bad_id_first;
      test_check_once(0, 1, 2'b01, $urandom | 32'h1, 32'h0, "bad_id_first");
   endtask

   task automatic test_timeout;
      int n, r0, d0;
      bit got;
      n_bad[0] = 0;
      r0 = ts_rd_cycles[0];
      d0 = done_cnt[0];
      stall_ts[0] = 1'b1;
      @(negedge clock);
      start[0] = 1'b1;
      n = 0;
      got = 1'b0;
      while (!got && n < 400) begin
         @(negedge clock);
         start[0] = 1'b0;
         n++;
         got = (done[0] === 1'b1);
      end
      n_checks++;
      if (!got || n != 257) begin
         n_fail++; $display("FAIL timeout_cycle: got %0d (seen %0b) want 257", n, got);
      end
      n_checks++;
      if ({timeout[0], pass[0], mismatch[0], avm_read[0], busy[0]} !== 5'b10000) begin
         n_fail++; $display("FAIL timeout_flags: got %b want 10000",
                            {timeout[0], pass[0], mismatch[0], avm_read[0], busy[0]});
      end
      n_checks++;
      if (id_value[0] !== EXP_ID || ts_value[0] !== last_ts[0]) begin
         n_fail++; $display("FAIL timeout_words: got %h/%h want %h/%h",
                            id_value[0], ts_value[0], EXP_ID, last_ts[0]);
      end
      repeat (2) @(negedge clock);
      stall_ts[0] = 1'b0;
      n_checks++;
      if (ts_rd_cycles[0] - r0 != 255 || done_cnt[0] - d0 != 1) begin
         n_fail++; $display("FAIL timeout_len: got %0d read cycles %0d dones want 255 1",
                            ts_rd_cycles[0] - r0, done_cnt[0] - d0);
      end
      last_id[0] = EXP_ID;
   endtask

   task automatic test_latency_stall;
      logic [31:0] bad;
      int n, d0;
      bit got;
      bad = EXP_ID ^ ($urandom | 32'h1);
      n_bad[1] = 1; bad_sel[1] = 2'b01; mask_id[1] = bad ^ EXP_ID;
      base_id[1] = id_acc[1]; base_ts[1] = ts_acc[1];
      d0 = done_cnt[1];
      wr_base[1] = 1'b1;
      @(negedge clock);
      start[1] = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         start[1] = 1'b0;
         n_checks++;
         if ({avm_read[1], avm_address[1]} !== 2'b10) begin
            n_fail++; $display("FAIL stall_stable[%0d]: got %b want 10", c,
                               {avm_read[1], avm_address[1]});
         end
      end
      wr_base[1] = 1'b0;
      @(negedge clock);
      n_checks++;
      if (avm_read[1] !== 1'b0 || id_value[1] !== last_id[1]) begin
         n_fail++; $display("FAIL lat_wait1: got read %b id %h want 0 %h",
                            avm_read[1], id_value[1], last_id[1]);
      end
      @(negedge clock);
      n_checks++;
      if (id_value[1] !== last_id[1]) begin
         n_fail++; $display("FAIL lat_wait2: got %h want %h", id_value[1], last_id[1]);
      end
      @(negedge clock);
      n_checks++;
      if (id_value[1] !== bad) begin
         n_fail++; $display("FAIL lat_capture: got %h want %h", id_value[1], bad);
      end
      n = 0;
      while (retry_count[1] !== 2'd1 && n < 50) begin @(negedge clock); n++; end
      start[1] = 1'b1;
      @(negedge clock);
      start[1] = 1'b0;
      n_checks++;
      if (retry_count[1] !== 2'd1 || busy[1] !== 1'b1) begin
         n_fail++; $display("FAIL busy_start: got retry %0d busy %b want 1 1",
                            retry_count[1], busy[1]);
      end
      n = 0;
      got = 1'b0;
      while (!got && n < 100) begin @(negedge clock); n++; got = (done[1] === 1'b1); end
      n_checks++;
      if (!got || {pass[1], mismatch[1], timeout[1], retry_count[1]} !== 5'b10001) begin
         n_fail++; $display("FAIL lat_result: got %b (seen %0b) want 10001",
                            {pass[1], mismatch[1], timeout[1], retry_count[1]}, got);
      end
      repeat (2) @(negedge clock);
      n_checks++;
      if (done_cnt[1] - d0 != 1 || id_value[1] !== EXP_ID) begin
         n_fail++; $display("FAIL lat_single_done: got %0d id %h want 1 %h",
                            done_cnt[1] - d0, id_value[1], EXP_ID);
      end
      last_id[1] = EXP_ID;
      last_ts[1] = EXP_TS;
   endtask

   task automatic test_reset_midread;
      logic [75:0] outs;
      int n;
      n_bad[0] = 0;
      n_bad[1] = 0;
      @(negedge clock);
      start[1] = 1'b1;
      @(negedge clock);
      start[1] = 1'b0;
      @(negedge clock);
      n_checks++;
      if ({avm_read[1], busy[1]} !== 2'b01) begin
         n_fail++; $display("FAIL pre_reset_wait: got %b want 01", {avm_read[1], busy[1]});
      end
      #2 reset_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         outs = {avm_read[k], avm_address[k], busy[k], done[k], pass[k], mismatch[k],
                 timeout[k], retry_count[k], id_value[k], ts_value[k]};
         n_checks++;
         if (outs !== 76'h0) begin
            n_fail++; $display("FAIL async_reset[%0d]: got %h want 0", k, outs);
         end
      end
      @(negedge clock);
      reset_n = 1'b1;
      n = 0;
      while ((busy[0] !== 1'b0 || busy[1] !== 1'b0 || n < 2) && n < 40) begin
         @(negedge clock); n++;
      end
      n_checks++;
      if ({pass[0], pass[1], busy[0], busy[1]} !== 4'b1100) begin
         n_fail++; $display("FAIL restart_after_reset: got %b want 1100",
                            {pass[0], pass[1], busy[0], busy[1]});
      end
      for (int k = 0; k < 2; k++) begin last_id[k] = EXP_ID; last_ts[k] = EXP_TS; end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < 2; k++) begin
         start[k] = 1'b0; n_bad[k] = 0; bad_sel[k] = 2'b00; mask_id[k] = '0; mask_ts[k] = '0;
         base_id[k] = 0; base_ts[k] = 0; wr_base[k] = 1'b0; stall_ts[k] = 1'b0;
      end
      test_reset;
      test_auto_start;
      test_random;
      test_ts_zero;
      test_bad_id_first;
      test_timeout;
      test_latency_stall;
      test_reset_midread;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
